tx_rr_arbiter: RTL and testbench

Round-robin read arbiter for the transmission layer: drains up to four upstream FIFOs into one downstream FIFO. It watches each upstream FIFO's empty flag, issues at most one single-word read per cycle, and forwards the registered read data as a downstream write one cycle later. Downstream space is tracked with an internal credit counter, so the arbiter never overflows the downstream FIFO and never underflows an upstream one. Neither FIFO guards against misuse, so this protection is the arbiter's job.

---
 rtl/tx_rr_arbiter_pkg.sv | 22 ++
 rtl/tx_rr_arbiter_rr_pick.sv | 36 +++
 rtl/tx_rr_arbiter.sv | 89 ++++++++
 tb/tb_tx_rr_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tx_rr_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tx_rr_arbiter_pkg                                           |
// | Brief   : Shared constants and types for the tx round-robin arbiter.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package tx_rr_arbiter_pkg;

   localparam int c_num_inputs = 4;
   localparam int c_down_depth = 4;

   // Credit counter must hold the value down_depth itself, hence the +1.
   function automatic int credit_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int c_credit_w = credit_width(c_down_depth);

   typedef logic [1:0] idx_t;

endpackage
`default_nettype wire

// File: rtl/tx_rr_arbiter_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rr_pick                                                     |
// | Brief   : Combinational round-robin pick, searching up from last+1.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rr_pick
   import tx_rr_arbiter_pkg::*;
(
   input  logic [c_num_inputs-1:0] i_req,
   input  idx_t                    i_last_grant,
   output idx_t                    o_pick,
   output logic                    o_any_req
);

   idx_t w_idx;
   logic w_found;

   always_comb begin
      o_pick  = '0;
      w_found = 1'b0;
      w_idx   = i_last_grant;
      // Offset 4 wraps back to last_grant, so a lone requester re-wins.
      for (int k = 1; k <= c_num_inputs; k++) begin
         w_idx = i_last_grant + idx_t'(k);
         if (!w_found && i_req[w_idx]) begin
            o_pick  = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign o_any_req = |i_req;

endmodule
`default_nettype wire

// File: rtl/tx_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tx_rr_arbiter                                               |
// | Brief   : Credit-guarded round-robin drain of four FIFOs into one.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tx_rr_arbiter
   import tx_rr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 6,
   parameter int NUM_INPUTS = c_num_inputs,
   parameter int DOWN_DEPTH = c_down_depth
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_INPUTS-1:0]            empty_in,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
   input  logic                             down_rd,
   output logic [NUM_INPUTS-1:0]            rd_enable_out,
   output logic                             wr_enable_out,
   output logic [DATA_WIDTH-1:0]            data_out,
   output logic                             error
);

   localparam int              c_cw   = credit_width(DOWN_DEPTH);
   localparam logic [c_cw-1:0] c_full = c_cw'(DOWN_DEPTH);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   idx_t            r_last_grant;
   idx_t            r_sel;
   logic [c_cw-1:0] r_credits;
   logic            r_valid;
   logic            r_err;

   logic [NUM_INPUTS-1:0] w_req;
   idx_t                  w_pick;
   logic                  w_any_req;
   logic                  w_issue;

   assign w_req = ~empty_in;

   rr_pick u_pick (
      .i_req        (w_req),
      .i_last_grant (r_last_grant),
      .o_pick       (w_pick),
      .o_any_req    (w_any_req)
   );

   // Gating with reset keeps the read strobe low while reset is held.
   assign w_issue = reset && w_any_req && (r_credits != '0);

   always_comb begin
      rd_enable_out = '0;
      if (w_issue) begin
         rd_enable_out[w_pick] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_credits    <= c_full;
         r_last_grant <= idx_t'(3);
         r_sel        <= '0;
         r_valid      <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_valid <= w_issue;
         if (w_issue) begin
            r_last_grant <= w_pick;
            r_sel        <= w_pick;
         end
         if (w_issue && !down_rd) begin
            r_credits <= r_credits - c_one;
         end else if (!w_issue && down_rd) begin
            if (r_credits == c_full) begin
               r_err <= 1'b1;
            end else begin
               r_credits <= r_credits + c_one;
            end
         end
      end
   end

   assign wr_enable_out = r_valid;
   assign data_out      = data_in[int'(r_sel)*DATA_WIDTH +: DATA_WIDTH];
   assign error         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tx_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_tx_rr_arbiter                                            |
// | Brief   : Directed scoreboard bench for tx_rr_arbiter.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_tx_rr_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  empty_in;
   logic [23:0] data_in;
   logic        down_rd;
   logic [3:0]  rd_enable_out;
   logic        wr_enable_out;
   logic [5:0]  data_out;
   logic        error;

   int n_vec;
   int n_bad;

   int         m_cred;
   int         m_last;
   logic       m_err;
   logic [5:0] sb_q[$];

   tx_rr_arbiter #(
      .DATA_WIDTH (6),
      .NUM_INPUTS (4),
      .DOWN_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .empty_in      (empty_in),
      .data_in       (data_in),
      .down_rd       (down_rd),
      .rd_enable_out (rd_enable_out),
      .wr_enable_out (wr_enable_out),
      .data_out      (data_out),
      .error         (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus, compare against the model, then advance it.
   task automatic step(input logic [3:0] e, input logic dr);
      logic       issue;
      int         pick;
      logic [3:0] exp_rd;
      logic [5:0] exp_d;
      empty_in = e;
      down_rd  = dr;
      @(negedge clk);
      issue = (m_cred > 0) && (e != 4'hF);
      pick  = 0;
      for (int k = 4; k >= 1; k--) begin
         if (!e[(m_last + k) % 4]) pick = (m_last + k) % 4;
      end
      exp_rd = issue ? 4'(1 << pick) : 4'h0;
      chk("rd_enable", 32'(rd_enable_out), 32'(exp_rd));
      if (sb_q.size() > 0) begin
         exp_d = sb_q.pop_front();
         chk("wr_enable", 32'(wr_enable_out), 32'd1);
         chk("data_out", 32'(data_out), 32'(exp_d));
      end else begin
         chk("wr_enable", 32'(wr_enable_out), 32'd0);
      end
      chk("error", 32'(error), 32'(m_err));
      chk("credits", 32'(dut.r_credits), 32'(m_cred));
      if (issue && !dr) begin
         m_cred--;
      end else if (!issue && dr) begin
         if (m_cred == 4) m_err = 1'b1;
         else m_cred++;
      end
      if (issue) begin
         m_last = pick;
         sb_q.push_back(data_in[pick*6 +: 6]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #1;
      chk("rst_rd_enable", 32'(rd_enable_out), 32'd0);
      chk("rst_wr_enable", 32'(wr_enable_out), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      m_cred = 4;
      m_last = 3;
      m_err  = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      reset    = 1'b0;
      empty_in = 4'h0;
      down_rd  = 1'b1;
      data_in  = {6'h04, 6'h33, 6'h22, 6'h11};
      #2;
      apply_reset();
      chk("credits_after_reset", 32'(dut.r_credits), 32'd4);

      // Full round-robin: four grants in order, then out of credits.
      for (int i = 0; i < 6; i++) step(4'h0, 1'b0);
      chk("credits_drained", 32'(dut.r_credits), 32'd0);

      // Credit stall: a single returned credit allows exactly one read.
      step(4'h0, 1'b1);
      step(4'h0, 1'b0);
      step(4'h0, 1'b0);
      step(4'h0, 1'b0);

      for (int i = 0; i < 4; i++) step(4'hF, 1'b1);

      // Single source with concurrent pops keeps credits level.
      for (int i = 0; i < 3; i++) step(4'b1011, 1'b1);
      step(4'hF, 1'b0);
      chk("credits_single_src", 32'(dut.r_credits), 32'd4);

      // Overflow: pop with full credits sets the sticky error.
      step(4'hF, 1'b1);
      for (int i = 0; i < 10; i++) step(4'hF, 1'b0);
      chk("error_sticky", 32'(error), 32'd1);

      // Mid-stream reset while a write is in flight.
      step(4'h0, 1'b0);
      chk("wr_before_reset", 32'(wr_enable_out), 32'd1);
      apply_reset();
      step(4'h0, 1'b0);
      step(4'hF, 1'b0);
      step(4'hF, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
